// File: rtl/seq_program_runner_if.sv
// Bundle between the program runner and whoever feeds it: host program/start
// controls, the sequencer status inputs and the runner's status outputs.
interface seq_program_runner_if #(
    parameter int DEPTH = 16,
    parameter int CMD_W = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             prog_wr_en_i;
    logic [AW-1:0]    prog_addr_i;
    logic [CMD_W-1:0] prog_data_i;
    logic [AW:0]      prog_len_i;
    logic             start_i;
    logic             abort_i;
    logic             seq_busy_i;
    logic [7:0]       seq_repeat_cnt_i;
    logic             seq_eof_i;
    logic [CMD_W-1:0] cmd_id_o;
    logic             run_busy_o;
    logic             run_done_o;
    logic             run_error_o;
    logic [AW-1:0]    step_idx_o;
    logic [7:0]       repeat_idx_o;

    // Host / sequencer side
    modport master (
        output prog_wr_en_i, prog_addr_i, prog_data_i, prog_len_i,
               start_i, abort_i, seq_busy_i, seq_repeat_cnt_i, seq_eof_i,
        input  cmd_id_o, run_busy_o, run_done_o, run_error_o,
               step_idx_o, repeat_idx_o
    );

    // Runner side
    modport slave (
        input  prog_wr_en_i, prog_addr_i, prog_data_i, prog_len_i,
               start_i, abort_i, seq_busy_i, seq_repeat_cnt_i, seq_eof_i,
        output cmd_id_o, run_busy_o, run_done_o, run_error_o,
               step_idx_o, repeat_idx_o
    );
endinterface

// File: rtl/seq_program_runner.sv
// Program runner: steps through a host-loaded list of command IDs, issuing
// each one to the sequencer for a single cycle, repeating it as many times as
// the sequencer reports, and ending on end-of-program, sequencer EOF, issue
// timeout or abort. All status outputs come straight from registers.
module seq_program_runner #(
    parameter int               DEPTH    = 16,
    parameter int               CMD_W    = 8,
    parameter logic [CMD_W-1:0] IDLE_CMD = 8'h00,
    parameter int               TO_CYC   = 1023,
    parameter int               AW       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    seq_program_runner_if.slave   bus
);

    localparam int            TOW     = $clog2(TO_CYC + 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TO_CYC);
    localparam logic [AW:0]   LEN_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   LEN_ZERO = {(AW+1){1'b0}};

    typedef enum logic [2:0] {
        RUN_IDLE  = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        FINISH    = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [AW:0]      len_q, len_d;
    logic [AW-1:0]    step_q, step_d;
    logic [7:0]       rep_q, rep_d;
    logic [7:0]       rep_total_q, rep_total_d;
    logic             eof_q, eof_d;
    logic [TOW-1:0]   to_cnt_q, to_cnt_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Program storage is deliberately not reset so it survives a mid-run reset
    logic [CMD_W-1:0] prog_mem [DEPTH];

    // Host writes land only while no run is in progress
    always_ff @(posedge clk) begin
        if (bus.prog_wr_en_i && !busy_q) begin
            prog_mem[bus.prog_addr_i] <= bus.prog_data_i;
        end
    end

    // State and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN_IDLE;
            len_q       <= LEN_ZERO;
            step_q      <= {AW{1'b0}};
            rep_q       <= 8'd0;
            rep_total_q <= 8'd0;
            eof_q       <= 1'b0;
            to_cnt_q    <= {TOW{1'b0}};
            cmd_q       <= IDLE_CMD;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            step_q      <= step_d;
            rep_q       <= rep_d;
            rep_total_q <= rep_total_d;
            eof_q       <= eof_d;
            to_cnt_q    <= to_cnt_d;
            cmd_q       <= cmd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic; abort overrides everything once a run is active
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        step_d      = step_q;
        rep_d       = rep_q;
        rep_total_d = rep_total_q;
        eof_d       = eof_q;
        to_cnt_d    = to_cnt_q;
        cmd_d       = IDLE_CMD;
        err_d       = err_q;

        case (state_q)
            RUN_IDLE: begin
                if (bus.start_i) begin
                    err_d  = 1'b0;
                    step_d = {AW{1'b0}};
                    rep_d  = 8'd0;
                    if (bus.prog_len_i == LEN_ZERO) begin
                        state_d = FINISH;
                    end else begin
                        len_d   = bus.prog_len_i;
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = RUN_IDLE;
                end
            end
            ISSUE: begin
                // Hold off until the sequencer has finished the previous command
                if (!bus.seq_busy_i) begin
                    cmd_d    = prog_mem[step_q];
                    to_cnt_d = {TOW{1'b0}};
                    state_d  = WAIT_BUSY;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT_BUSY: begin
                if (bus.seq_busy_i) begin
                    // Repeat total is fixed by the first iteration of a step
                    if (rep_q == 8'd0) begin
                        rep_total_d = (bus.seq_repeat_cnt_i == 8'd0) ? 8'd1
                                                                     : bus.seq_repeat_cnt_i;
                    end else begin
                        rep_total_d = rep_total_q;
                    end
                    eof_d   = bus.seq_eof_i;
                    state_d = WAIT_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = RUN_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + {{(TOW-1){1'b0}}, 1'b1};
                end
            end
            WAIT_DONE: begin
                if (!bus.seq_busy_i) begin
                    if (({1'b0, rep_q} + 9'd1) < {1'b0, rep_total_q}) begin
                        rep_d   = rep_q + 8'd1;
                        state_d = ISSUE;
                    end else if (eof_q) begin
                        state_d = FINISH;
                    end else if (({1'b0, step_q} + LEN_ONE) == len_q) begin
                        state_d = FINISH;
                    end else begin
                        step_d  = step_q + {{(AW-1){1'b0}}, 1'b1};
                        rep_d   = 8'd0;
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            FINISH: begin
                state_d = RUN_IDLE;
            end
            default: begin
                state_d = RUN_IDLE;
            end
        endcase

        if ((state_q != RUN_IDLE) && bus.abort_i) begin
            state_d = RUN_IDLE;
            err_d   = 1'b1;
            cmd_d   = IDLE_CMD;
        end else begin
            err_d = err_d;
        end

        busy_d = (state_d != RUN_IDLE);
        done_d = (state_d == FINISH);
    end

    assign bus.cmd_id_o     = cmd_q;
    assign bus.run_busy_o   = busy_q;
    assign bus.run_done_o   = done_q;
    assign bus.run_error_o  = err_q;
    assign bus.step_idx_o   = step_q;
    assign bus.repeat_idx_o = rep_q;

endmodule
